// File: rtl/fc_pkg.sv
// Shared types and defaults for the fully-connected layer control path.
package fc_pkg;

  localparam int DEFAULT_INPUT_SZ    = 4;
  localparam int DEFAULT_MAX_INPUTS  = 256;
  localparam int DEFAULT_MAX_OUTPUTS = 128;
  localparam int DEFAULT_SIZE        = DEFAULT_MAX_INPUTS;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FETCH,
    LOAD_W,
    LOAD_V,
    ACC,
    WRITE,
    DONE
  } state_t;

  // ALU operand-register load select
  typedef enum logic [1:0] {
    LOAD_VALUES       = 2'd0,
    LOAD_BIAS_WEIGHTS = 2'd1,
    LOAD_UD           = 2'd2,
    LOAD_HOLD         = 2'd3
  } load_en_t;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/fc_loop_counter.sv
// Up-counter with synchronous clear/increment and a flag for reaching the
// final index of a loop.
module fc_loop_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         incr,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         last
);

  // count register; clear wins over increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        count <= '0;
    else if (clear) count <= '0;
    else if (incr)  count <= count + W'(1);
  end

  assign last = (count == limit);

endmodule

// File: rtl/alu_sequencer.sv
// Sequences the MAC ALU through a full fully-connected layer pass:
// per neuron, clear, stream weight/value chunks, then hand off the result.
//
// state  | meaning
// IDLE   | waiting for start
// CLEAR  | clear accumulator, reset chunk index
// FETCH  | read weight and value memories for chunk c
// LOAD_W | load bias+weights into ALU (bias masked after chunk 0)
// LOAD_V | load activation values into ALU
// ACC    | accumulate chunk; loop or finish neuron
// WRITE  | present neuron result until out_ready
// DONE   | one-cycle completion pulse
module alu_sequencer
  import fc_pkg::*;
#(
  parameter int INPUT_SZ    = DEFAULT_INPUT_SZ,
  parameter int MAX_INPUTS  = DEFAULT_MAX_INPUTS,
  parameter int MAX_OUTPUTS = DEFAULT_MAX_OUTPUTS,
  parameter int CHUNK_W     = $clog2((MAX_INPUTS + INPUT_SZ - 1) / INPUT_SZ + 1),
  parameter int WADDR_W     = $clog2(MAX_OUTPUTS * ((MAX_INPUTS + INPUT_SZ - 1) / INPUT_SZ)),
  parameter int NI_W        = $clog2(MAX_INPUTS + 1),
  parameter int NO_W        = $clog2(MAX_OUTPUTS + 1),
  parameter int IDX_W       = $clog2(MAX_OUTPUTS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NI_W-1:0]    num_inputs,
  input  logic [NO_W-1:0]    num_outputs,
  output logic               busy,
  output logic               done,
  output logic               w_rd,
  output logic [WADDR_W-1:0] w_addr,
  output logic               v_rd,
  output logic [CHUNK_W-1:0] v_addr,
  output logic [1:0]         alu_load_enable,
  output logic               alu_enable,
  output logic               alu_clear,
  output logic               bias_zero,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   out_idx
);

  state_t state, state_d;

  logic [CHUNK_W-1:0] chunks_new, chunks_q, c_lim_q, c_cnt;
  logic [IDX_W-1:0]   j_lim_q, j_cnt;
  logic [WADDR_W-1:0] w_base;
  logic               c_last, j_last, accept, handshake;

  logic               busy_d, done_d, rd_d, alu_enable_d, alu_clear_d;
  logic               bias_zero_d, out_valid_d;
  logic [1:0]         load_d;
  logic [WADDR_W-1:0] w_addr_d;
  logic [CHUNK_W-1:0] v_addr_d;
  logic [IDX_W-1:0]   out_idx_d;

  assign chunks_new = CHUNK_W'(ceil_div(int'(num_inputs), INPUT_SZ));
  assign accept     = (state == IDLE) && start && (num_inputs != '0) && (num_outputs != '0);
  assign handshake  = (state == WRITE) && out_ready;

  fc_loop_counter #(.W(CHUNK_W)) u_chunk_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (state == CLEAR),
    .incr  ((state == ACC) && !c_last),
    .limit (c_lim_q),
    .count (c_cnt),
    .last  (c_last)
  );

  fc_loop_counter #(.W(IDX_W)) u_neuron_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .incr  (handshake && !j_last),
    .limit (j_lim_q),
    .count (j_cnt),
    .last  (j_last)
  );

  // pass configuration and running weight base (j*chunks without a multiplier)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chunks_q <= '0;
      c_lim_q  <= '0;
      j_lim_q  <= '0;
      w_base   <= '0;
    end else if (accept) begin
      chunks_q <= chunks_new;
      c_lim_q  <= chunks_new - CHUNK_W'(1);
      j_lim_q  <= IDX_W'(num_outputs - NO_W'(1));
      w_base   <= '0;
    end else if (handshake && !j_last) begin
      w_base   <= w_base + WADDR_W'(chunks_q);
    end
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // next state, plus the values the outputs take in that next state
  always_comb begin
    state_d      = state;
    w_addr_d     = w_addr;
    v_addr_d     = v_addr;
    out_idx_d    = out_idx;
    bias_zero_d  = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          if ((num_inputs == '0) || (num_outputs == '0)) state_d = DONE;
          else                                           state_d = CLEAR;
        end
      end
      CLEAR: begin
        state_d  = FETCH;
        w_addr_d = w_base;
        v_addr_d = '0;
      end
      FETCH: begin
        state_d     = LOAD_W;
        bias_zero_d = (c_cnt != '0);
      end
      LOAD_W: state_d = LOAD_V;
      LOAD_V: state_d = ACC;
      ACC: begin
        if (c_last) begin
          state_d   = WRITE;
          out_idx_d = j_cnt;
        end else begin
          state_d  = FETCH;
          w_addr_d = w_addr + WADDR_W'(1);
          v_addr_d = c_cnt + CHUNK_W'(1);
        end
      end
      WRITE: begin
        if (out_ready) state_d = j_last ? DONE : CLEAR;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d       = (state_d != IDLE) && (state_d != DONE);
    done_d       = (state_d == DONE);
    rd_d         = (state_d == FETCH);
    alu_clear_d  = (state_d == CLEAR);
    alu_enable_d = (state_d == ACC);
    out_valid_d  = (state_d == WRITE);
    if (state_d == LOAD_W)      load_d = LOAD_BIAS_WEIGHTS;
    else if (state_d == LOAD_V) load_d = LOAD_VALUES;
    else                        load_d = LOAD_HOLD;
  end

  // registered Moore outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy            <= 1'b0;
      done            <= 1'b0;
      w_rd            <= 1'b0;
      v_rd            <= 1'b0;
      w_addr          <= '0;
      v_addr          <= '0;
      alu_load_enable <= LOAD_HOLD;
      alu_enable      <= 1'b0;
      alu_clear       <= 1'b0;
      bias_zero       <= 1'b0;
      out_valid       <= 1'b0;
      out_idx         <= '0;
    end else begin
      busy            <= busy_d;
      done            <= done_d;
      w_rd            <= rd_d;
      v_rd            <= rd_d;
      w_addr          <= w_addr_d;
      v_addr          <= v_addr_d;
      alu_load_enable <= load_d;
      alu_enable      <= alu_enable_d;
      alu_clear       <= alu_clear_d;
      bias_zero       <= bias_zero_d;
      out_valid       <= out_valid_d;
      out_idx         <= out_idx_d;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: table vectors, random passes and
// hand-written reset / busy-start sequences against a loop-level model.
module tb_alu_sequencer;

  localparam int INPUT_SZ = 4;
  localparam int NI_W     = 9;
  localparam int NO_W     = 8;
  localparam int CHUNK_W  = 7;
  localparam int WADDR_W  = 13;
  localparam int IDX_W    = 7;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [NI_W-1:0]    num_inputs;
  logic [NO_W-1:0]    num_outputs;
  logic               busy, done, w_rd, v_rd, alu_enable, alu_clear, bias_zero, out_valid;
  logic               out_ready;
  logic [WADDR_W-1:0] w_addr;
  logic [CHUNK_W-1:0] v_addr;
  logic [1:0]         alu_load_enable;
  logic [IDX_W-1:0]   out_idx;

  int checks = 0;
  int passes = 0;

  typedef struct {
    int ni;
    int no;
    int stall;
    int inject;
    int exp_done;
  } vec_t;

  vec_t tab[12];

  alu_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .num_inputs      (num_inputs),
    .num_outputs     (num_outputs),
    .busy            (busy),
    .done            (done),
    .w_rd            (w_rd),
    .w_addr          (w_addr),
    .v_rd            (v_rd),
    .v_addr          (v_addr),
    .alu_load_enable (alu_load_enable),
    .alu_enable      (alu_enable),
    .alu_clear       (alu_clear),
    .bias_zero       (bias_zero),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_idx         (out_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int q_diff(input int a[$], input int b[$]);
    int n = 0;
    if (a.size() != b.size()) return 1000000;
    foreach (a[i]) if (a[i] != b[i]) n++;
    return n;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, ".strobes"},
          int'({busy, done, w_rd, v_rd, alu_enable, alu_clear, out_valid, bias_zero, alu_load_enable}),
          3);
    check({tag, ".addrs"}, int'(w_addr) + int'(v_addr) + int'(out_idx), 0);
  endtask

  // Called at a negedge with the DUT idle; start is driven immediately.
  // The model expands the nested neuron/chunk loops directly.
  task automatic run_pass(input int ni, input int no, input int stall, input int inject,
                          input int tab_done, input string tag);
    int ch, n_eff, exp_lat, s;
    int stalls[$], exp_w[$], exp_v[$], exp_bz[$];
    int got_w[$], got_v[$], got_bz[$];
    int n_en = 0, n_clr = 0, k = 0, waitc = 0, done_cyc = -1, busy_bad = 0, idx_bad = 0;

    ch      = (ni + INPUT_SZ - 1) / INPUT_SZ;
    n_eff   = (ni == 0 || no == 0) ? 0 : no;
    exp_lat = 1;
    for (int j = 0; j < n_eff; j++) begin
      s = (stall >= 0) ? stall : int'($urandom_range(0, 3));
      stalls.push_back(s);
      exp_lat += 2 + 4 * ch + s;
      for (int c = 0; c < ch; c++) begin
        exp_w.push_back(j * ch + c);
        exp_v.push_back(c);
        exp_bz.push_back((c != 0) ? 1 : 0);
      end
    end

    start       = 1'b1;
    num_inputs  = NI_W'(ni);
    num_outputs = NO_W'(no);
    out_ready   = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    num_inputs  = NI_W'($urandom);
    num_outputs = NO_W'($urandom);

    for (int cyc = 1; cyc <= 6000; cyc++) begin
      if (w_rd) begin
        got_w.push_back(int'(w_addr));
        got_v.push_back(int'(v_addr));
      end
      if (alu_load_enable == 2'd1) got_bz.push_back(int'(bias_zero));
      if (alu_enable) n_en++;
      if (alu_clear)  n_clr++;
      if (done) begin
        done_cyc = cyc;
        if (busy) busy_bad++;
        break;
      end
      if (!busy) busy_bad++;
      start = 1'b0;
      if (cyc == inject) begin
        start       = 1'b1;
        num_inputs  = NI_W'($urandom_range(1, 256));
        num_outputs = NO_W'($urandom_range(1, 128));
      end
      if (out_valid) begin
        if (k >= n_eff || int'(out_idx) != k) idx_bad++;
        if (k < n_eff && waitc < stalls[k]) begin
          out_ready = 1'b0;
          waitc++;
        end else begin
          out_ready = 1'b1;
          k++;
          waitc = 0;
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    start = 1'b0;

    check({tag, ".done_cycle"}, done_cyc, exp_lat);
    if (tab_done >= 0) check({tag, ".table_done"}, done_cyc, tab_done);
    check({tag, ".w_addr_seq"}, q_diff(got_w, exp_w), 0);
    check({tag, ".v_addr_seq"}, q_diff(got_v, exp_v), 0);
    check({tag, ".bias_zero_seq"}, q_diff(got_bz, exp_bz), 0);
    check({tag, ".alu_enable_cnt"}, n_en, n_eff * ch);
    check({tag, ".alu_clear_cnt"}, n_clr, n_eff);
    check({tag, ".handshakes"}, k, n_eff);
    check({tag, ".out_idx_bad"}, idx_bad, 0);
    check({tag, ".busy_bad"}, busy_bad, 0);
    @(negedge clk);
    check({tag, ".done_width"}, int'({done, busy}), 0);
  endtask

  initial begin
    int hit;
    int done_seen;

    tab[0]  = '{8,   2,   0, -1, 21};
    tab[1]  = '{5,   3,   0, -1, 31};
    tab[2]  = '{8,   1,   5, -1, 16};
    tab[3]  = '{0,   3,   0, -1, 1};
    tab[4]  = '{7,   0,   0, -1, 1};
    tab[5]  = '{4,   1,   0, -1, 7};
    tab[6]  = '{1,   3,   1, -1, 22};
    tab[7]  = '{256, 1,   0, -1, 259};
    tab[8]  = '{12,  2,   0,  6, 29};
    tab[9]  = '{13,  2,   2, -1, 41};
    tab[10] = '{255, 2,   0, -1, 517};
    tab[11] = '{4,   128, 0, -1, 769};

    rst         = 1'b1;
    start       = 1'b0;
    num_inputs  = '0;
    num_outputs = '0;
    out_ready   = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++)
      run_pass(tab[i].ni, tab[i].no, tab[i].stall, tab[i].inject, tab[i].exp_done,
               $sformatf("vec%0d", i));

    for (int i = 0; i < 12; i++)
      run_pass(int'($urandom_range(0, 40)), int'($urandom_range(0, 6)), -1,
               ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 5)) : -1, -1,
               $sformatf("rnd%0d", i));

    // reset in the middle of chunk 1 of neuron 3 (w_addr 3*2+1)
    start       = 1'b1;
    num_inputs  = NI_W'(8);
    num_outputs = NO_W'(5);
    out_ready   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit   = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      if (w_rd && w_addr == WADDR_W'(7)) begin
        hit = 1;
        break;
      end
      @(negedge clk);
    end
    check("mid_rst.reached_fetch", hit, 1);
    rst = 1'b1;
    #1;
    check_reset_values("mid_rst");
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("mid_rst.no_done", done_seen, 0);
    run_pass(4, 1, 0, -1, 7, "post_rst");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
